// File: rtl/ebpc_pkg.sv
// Shared EBPC decoder constants and the bit-unstreamer state type.
package ebpc_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned UNSTREAM_CNT_W = $clog2(2*DATA_W+1);
  localparam int unsigned UNSTREAM_SH_W  = $clog2(DATA_W+1);

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    AVAIL,
    DRAIN
  } unstream_state_t;

endpackage

// File: rtl/shift_unstreamer_if.sv
// Input-word and output-window handshake bundle of the shift unstreamer.
interface shift_unstreamer_if #(
  parameter int unsigned DATA_W = ebpc_pkg::DATA_W
);
  localparam int unsigned CNT_W = $clog2(2*DATA_W+1);
  localparam int unsigned SH_W  = $clog2(DATA_W+1);

  logic [DATA_W-1:0] data_i;
  logic              last_i;
  logic              vld_i;
  logic              rdy_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  avail_o;
  logic              vld_o;
  logic [SH_W-1:0]   shift_i;
  logic              rdy_i;

  modport master (
    output data_i, last_i, vld_i, shift_i, rdy_i,
    input  rdy_o, data_o, avail_o, vld_o
  );

  modport slave (
    input  data_i, last_i, vld_i, shift_i, rdy_i,
    output rdy_o, data_o, avail_o, vld_o
  );

endinterface

// File: rtl/shift_unstreamer.sv
// Packed-word to variable-length bit window converter (decoder side).
// Optional sticky protocol error output: define SHIFT_UNSTREAMER_ERR_EN.
module shift_unstreamer #(
  parameter int unsigned DATA_W = ebpc_pkg::DATA_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  shift_unstreamer_if.slave  bus,
`ifdef SHIFT_UNSTREAMER_ERR_EN
  output logic               err_o,
`endif
  output logic               idle_o
);
  import ebpc_pkg::*;

  localparam int unsigned BUF_W = 2*DATA_W;
  localparam int unsigned CNT_W = $clog2(2*DATA_W+1);

  unstream_state_t   state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  shift_ext, shift_lim, shift_eff, cnt_sh;
  logic              rdy, vld, in_xfer, out_xfer;

  assign rdy = (cnt_q <= CNT_W'(DATA_W)) && (state_q != DRAIN);
  assign vld = (state_q == AVAIL) || ((state_q == DRAIN) && (cnt_q != '0));

  assign bus.rdy_o   = rdy;
  assign bus.vld_o   = vld;
  assign bus.data_o  = buf_q[BUF_W-1 -: DATA_W];
  assign bus.avail_o = cnt_q;
  assign idle_o      = (state_q == EMPTY) && !bus.vld_i;

  // Datapath: consume first, then merge the new word right behind what is left.
  always_comb begin
    in_xfer   = bus.vld_i && rdy;
    out_xfer  = vld && bus.rdy_i;
    shift_ext = CNT_W'(bus.shift_i);
    shift_lim = (cnt_q < CNT_W'(DATA_W)) ? cnt_q : CNT_W'(DATA_W);
    shift_eff = '0;
    if (out_xfer) begin
      shift_eff = (shift_ext > shift_lim) ? shift_lim : shift_ext;
    end
    cnt_sh = cnt_q - shift_eff;
    buf_d  = buf_q << shift_eff;
    cnt_d  = cnt_sh;
    if (in_xfer) begin
      buf_d = buf_d | ({bus.data_i, {DATA_W{1'b0}}} >> cnt_sh);
      cnt_d = cnt_sh + CNT_W'(DATA_W);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY, FILL, AVAIL: begin
        if (in_xfer && bus.last_i) begin
          state_d = DRAIN;
        end else if (cnt_d == '0) begin
          state_d = EMPTY;
        end else if (cnt_d < CNT_W'(DATA_W)) begin
          state_d = FILL;
        end else begin
          state_d = AVAIL;
        end
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SHIFT_UNSTREAMER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (out_xfer && ((shift_ext > cnt_q) || (shift_ext > CNT_W'(DATA_W)))) begin
      err_d = 1'b1;
    end
    if (bus.vld_i && bus.last_i && (state_q == DRAIN)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_shift_unstreamer.sv
// Directed bench for shift_unstreamer with a bit-queue reference model.
module tb_shift_unstreamer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idle;
`ifdef SHIFT_UNSTREAMER_ERR_EN
  logic err;
`endif

  int total = 0;
  int bad   = 0;

  shift_unstreamer_if #(.DATA_W(W)) u ();

  shift_unstreamer #(.DATA_W(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (u.slave),
`ifdef SHIFT_UNSTREAMER_ERR_EN
    .err_o  (err),
`endif
    .idle_o (idle)
  );

  always #5 clk = ~clk;

  // Reference model: the window is simply an ordered queue of pending bits.
  bit mq[$];
  bit m_last;
  bit m_err;

  function automatic bit m_rdy();
    return (mq.size() <= W) && !m_last;
  endfunction

  function automatic bit m_vld();
    return m_last ? (mq.size() > 0) : (mq.size() >= W);
  endfunction

  function automatic logic [W-1:0] m_data();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (i < mq.size()) r[W-1-i] = mq[i];
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int n, sh, k;
    bit inx, outx;
    if (rst) begin
      mq.delete();
      m_last = 1'b0;
      m_err  = 1'b0;
    end else begin
      n    = mq.size();
      sh   = int'(u.shift_i);
      inx  = u.vld_i && m_rdy();
      outx = m_vld() && u.rdy_i;
      k    = (sh < n) ? sh : n;
      if (k > W) k = W;
      if (outx && (sh > n || sh > W)) m_err = 1'b1;
      if (u.vld_i && u.last_i && m_last) m_err = 1'b1;
      if (outx) repeat (k) void'(mq.pop_front());
      if (inx) begin
        for (int i = W-1; i >= 0; i--) mq.push_back(u.data_i[i]);
        if (u.last_i) m_last = 1'b1;
      end else if (m_last && mq.size() == 0) begin
        m_last = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_rdy",   32'(u.rdy_o),   32'(m_rdy()));
      chk("cmp_vld",   32'(u.vld_o),   32'(m_vld()));
      chk("cmp_avail", 32'(u.avail_o), 32'(mq.size()));
      chk("cmp_data",  32'(u.data_o),  32'(m_data()));
      chk("cmp_idle",  32'(idle),      32'(mq.size() == 0 && !m_last && !u.vld_i));
`ifdef SHIFT_UNSTREAMER_ERR_EN
      chk("cmp_err",   32'(err),       32'(m_err));
`endif
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                      input logic r, input logic [3:0] s);
    @(negedge clk);
    #1;
    u.vld_i   = v;
    u.data_i  = d;
    u.last_i  = l;
    u.rdy_i   = r;
    u.shift_i = s;
  endtask

  task automatic lit(input string nm, input logic [W-1:0] d, input int av,
                     input logic v, input logic r);
    chk({nm, "_data"},  32'(u.data_o),  32'(d));
    chk({nm, "_avail"}, 32'(u.avail_o), 32'(av));
    chk({nm, "_vld"},   32'(u.vld_o),   32'(v));
    chk({nm, "_rdy"},   32'(u.rdy_o),   32'(r));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    u.vld_i = 1'b0; u.data_i = '0; u.last_i = 1'b0; u.rdy_i = 1'b0; u.shift_i = '0;
    rst = 1'b1;
    #1;
    lit("rst", 8'h00, 0, 1'b0, 1'b1);
    chk("rst_idle", 32'(idle), 32'd1);
`ifdef SHIFT_UNSTREAMER_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    u.vld_i = 1'b0; u.data_i = '0; u.last_i = 1'b0; u.rdy_i = 1'b0; u.shift_i = '0;

    // 1: single last word, consumed as 3 then 5 bits
    do_reset();
    step(1'b1, 8'hA5, 1'b1, 1'b0, 4'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 4'd3);
    lit("t1a", 8'hA5, 8, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 4'd5);
    lit("t1b", 8'h28, 5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    lit("t1c", 8'h00, 0, 1'b0, 1'b1);
    chk("t1_idle", 32'(idle), 32'd1);

    // 2: streaming with 4-bit consumption
    do_reset();
    step(1'b1, 8'hF0, 1'b0, 1'b1, 4'd4);
    step(1'b1, 8'h0F, 1'b0, 1'b1, 4'd4);
    lit("t2a", 8'hF0, 8, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 4'd4);
    lit("t2b", 8'h00, 12, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 4'd4);
    lit("t2c", 8'h0F, 8, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    lit("t2d", 8'hF0, 4, 1'b0, 1'b1);

    // 3: back-pressure with a full window
    do_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0, 4'd0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h33, 1'b0, 1'b0, 4'd8);
      lit("t3_hold", 8'h11, 16, 1'b1, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 4'd8);
    step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    lit("t3_rel", 8'h22, 8, 1'b1, 1'b1);

    // 4: simultaneous consume and merge
    do_reset();
    step(1'b1, 8'hC3, 1'b0, 1'b0, 4'd0);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 4'd2);
    lit("t4a", 8'hC3, 8, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 4'd4);
    lit("t4b", 8'h0F, 14, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    lit("t4c", 8'hFF, 10, 1'b1, 1'b0);

    // 5: overlong shift while draining a partial window
    do_reset();
    step(1'b1, 8'hA5, 1'b1, 1'b0, 4'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 4'd5);
    step(1'b0, 8'h00, 1'b0, 1'b1, 4'd8);
    lit("t5a", 8'hA0, 3, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    lit("t5b", 8'h00, 0, 1'b0, 1'b1);
    chk("t5_idle", 32'(idle), 32'd1);
`ifdef SHIFT_UNSTREAMER_ERR_EN
    chk("t5_err", 32'(err), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    chk("t5_err_sticky", 32'(err), 32'd1);
`endif

    // 6: reset mid-stream with 11 bits buffered, then a clean word
    do_reset();
    step(1'b1, 8'hAB, 1'b0, 1'b0, 4'd0);
    step(1'b1, 8'hCD, 1'b0, 1'b1, 4'd5);
    step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    lit("t6_pre", 8'h79, 11, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 8'h5A, 1'b0, 1'b0, 4'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    lit("t6_post", 8'h5A, 8, 1'b1, 1'b1);

    step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_unstreamer.md
Name: shift_unstreamer

Overview:
- Decoder-side counterpart of the encoder's bit-packing stage.
- Accepts a stream of DATA_W-bit packed words and buffers them in a 2*DATA_W-bit MSB-aligned bit window.
- Presents the next DATA_W bits to the downstream symbol decoder, which consumes a variable number of bits (0..DATA_W) per handshake.
- Sits between the compressed-stream input and the ZNZ/BPC decoders.

Parameters:
- DATA_W, ebpc_pkg::DATA_W (8), width of packed input words and of the output window.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous active-high reset.
- data_i, in, DATA_W, packed input word; the MSB is the oldest bit.
- last_i, in, 1, marks data_i as the final word of the stream.
- vld_i, in, 1, input word valid.
- rdy_o, out, 1, ready to accept an input word.
- data_o, out, DATA_W, next DATA_W unconsumed bits, MSB-aligned; bits beyond cnt read 0.
- avail_o, out, $clog2(2*DATA_W+1), number of buffered bits (cnt).
- vld_o, out, 1, window valid.
- shift_i, in, $clog2(DATA_W+1), bits consumed on this handshake.
- rdy_i, in, 1, consumer takes shift_i bits.
- idle_o, out, 1, empty and no stream in progress.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state: buf_q=0, cnt_q=0, state EMPTY, and all outputs derived from these, so rdy_o=1, vld_o=0, idle_o=1, data_o=0, avail_o=0.
- buf_q is 2*DATA_W bits, MSB-aligned. Invariant: bits below position 2*DATA_W-cnt_q are 0.
- data_o = buf_q[2*DATA_W-1:DATA_W]; avail_o = cnt_q. Both are registered, with no combinational path from inputs.
- In transfer occurs when vld_i && rdy_o. Out transfer occurs when vld_o && rdy_i.
- rdy_o = (cnt_q <= DATA_W) && state != DRAIN. rdy_o depends only on registered state; it must not depend on rdy_i or shift_i.
- vld_o = (state==AVAIL) || (state==DRAIN && cnt_q>0).
- Out transfer: buf shifts left by shift_i, zero-filled; cnt -= shift_i.
- Simultaneous in and out transfers: consume first, then OR data_i into the buffer at offset cnt_q-shift_i from the MSB, i.e. buf_d = (buf_q<<shift_i) | ({data_i,DATA_W'0} >> (cnt_q-shift_i)), and cnt_d = cnt_q - shift_i + DATA_W. This never exceeds 2*DATA_W.
- State EMPTY (cnt=0):
  - idle_o=1 while vld_i=0.
  - On an in transfer: go to DRAIN if last_i, otherwise FILL. cnt becomes DATA_W, so without last_i the next state is AVAIL directly.
- State FILL (0<cnt<DATA_W, stream open): accept words; move to AVAIL when cnt_d >= DATA_W, or to DRAIN on last_i.
- State AVAIL (cnt >= DATA_W, stream open):
  - Serve the consumer.
  - Drop to FILL if cnt_d < DATA_W, or to EMPTY if cnt_d == 0.
  - An accepted last_i moves to DRAIN regardless of cnt_d.
- State DRAIN (last word received):
  - rdy_o=0; vld_o while cnt>0, and a partial window is allowed.
  - Go to EMPTY when cnt_d == 0.
  - last_i on a word accepted in the same cycle that DRAIN would be entered from EMPTY is handled identically.
- Overlong shift (shift_i > cnt_q, or shift_i > DATA_W): the shift is clamped to min(cnt_q, DATA_W) and cnt never underflows.
- vld_o and data_o hold stable while vld_o && !rdy_i. No output changes except through a handshake.
- Reset mid-stream: everything returns to the reset state immediately, and buffered bits are discarded.

Optional Feature:
- Macro: SHIFT_UNSTREAMER_ERR_EN.
- Defined: adds output err_o (1 bit, reset 0). err_o is sticky; it is set on an out transfer with shift_i > cnt_q or shift_i > DATA_W, and also on vld_i with last_i while in DRAIN. It is cleared only by reset.
- Undefined: no err_o port. Clamping behaviour is identical.

Decomposition:
- ebpc_pkg holds DATA_W and a new typedef unstream_state_t {EMPTY, FILL, AVAIL, DRAIN}.
- The counter width constant UNSTREAM_CNT_W = $clog2(2*DATA_W+1) also goes in ebpc_pkg.
- No sub-module. The shift/merge datapath stays inline in a single always_comb next to the FSM.

Test Plan (DATA_W=8):
1. Single word 0xA5 with last_i: consumer shifts 3, then 5 → data_o=0xA5, then 0x28 (avail 5), then idle_o=1, state EMPTY.
2. Words 0xF0, 0x0F (no last), consumer shift 4 each cycle with rdy_i=1 → data_o sequence 0xF0, 0x00, 0x0F; rdy_o never drops below the bandwidth needed; cnt is never >16.
3. Back-pressure: fill two words, rdy_i=0 for 5 cycles → rdy_o=0 once cnt=16; data_o and vld_o stable. Release with shift 8 → rdy_o=1 in the next cycle.
4. Simultaneous in/out: cnt=8 holding 0xC3, shift_i=2, data_i=0xFF → next data_o=0x0F, then bits 0xFF continue; avail=14.
5. Overlong shift in DRAIN with cnt=3, shift_i=8 → cnt=0, EMPTY; with SHIFT_UNSTREAMER_ERR_EN, err_o=1 and stays 1.
6. Assert rst_i mid-stream with cnt=11 → outputs return to reset values asynchronously; the first word after release appears intact on data_o.
